// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    // An all-zero word terminates the program.
    localparam logic [31:0] HALT_SENTINEL = 32'h0000_0000;
    localparam int          INSTR_BYTES   = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc, instruction} pairs between imem return and decode.
module fetch_fifo #(
    parameter  int DEPTH  = 2,
    parameter  int ADDR_W = 32,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [31:0]       push_instr,
    output logic [ADDR_W-1:0] head_pc,
    output logic [31:0]       head_instr,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] pc_mem  [DEPTH];
    logic [31:0]       ins_mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic              do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign do_pop     = pop & ~empty;
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = ins_mem[rd_ptr];

    // Pointer and occupancy update; clear wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            pc_mem[wr_ptr]  <= push_pc;
            ins_mem[wr_ptr] <= push_instr;
        end
    end

    // The issue throttle upstream must never let a push land on a full buffer.
    always_ff @(posedge clk) begin
        if (rst_n && push && !clear) assert (!full || do_pop);
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC sequencing, single-outstanding imem reads, buffered output to decode.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic              instruction_valid,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              done
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, inflight_pc, head_pc, redirect_aligned;
    logic [31:0]       head_instr;
    logic [CW-1:0]     count;
    logic [CW:0]       occ;
    logic              inflight, empty, full, pop, push, flush, zero_ret;

    assign flush            = redirect_valid && (state != IDLE);
    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
    assign instruction_valid = ~empty;
    assign pop              = instruction_valid & ~stall;
    assign zero_ret         = inflight && (imem_rdata == HALT_SENTINEL);
    assign push             = inflight && !zero_ret && !flush;
    // Slots that will be spoken for after this cycle if nothing new is issued.
    assign occ              = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);

    assign imem_addr   = pc;
    assign instruction = empty ? '0 : head_instr;
    assign fetch_pc    = empty ? '0 : head_pc;
    assign done        = (state == HALT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and issue decision; a returning sentinel blocks issue that same cycle.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN: begin
                if (zero_ret) state_nxt = DRAIN;
                else          imem_req  = (occ < (CW+1)'(FIFO_DEPTH));
            end
            DRAIN:   if (empty) state_nxt = HALT;
            HALT:    ;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = RUN;
            imem_req  = 1'b0;
        end
    end

    // PC and outstanding-read tracking; redirect discards the in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= imem_req;
            if (flush) begin
                pc <= redirect_aligned;
            end else if (imem_req) begin
                pc          <= pc + ADDR_W'(INSTR_BYTES);
                inflight_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .clear      (flush),
        .push_pc    (inflight_pc),
        .push_instr (imem_rdata),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed programs, monitor-side checking.
module tb_instruction_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } beat_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, stall, redirect_valid;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, instruction, fetch_pc;
    logic        imem_req, instruction_valid, done;

    logic        w_rst_n, w_start, w_stall, w_redir;
    logic [31:0] w_redir_pc, w_addr, w_rdata, w_instr, w_pc;
    logic        w_req, w_valid, w_done;

    int          total = 0;
    int          bad   = 0;
    beat_t       exp_q[$];
    beat_t       w_q[$];
    logic [31:0] prog [logic [31:0]];
    logic [31:0] max_addr;

    instruction_fetch #(.ADDR_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instruction(instruction), .instruction_valid(instruction_valid),
        .fetch_pc(fetch_pc), .done(done)
    );

    instruction_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(3)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .start(w_start), .stall(w_stall),
        .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .instruction(w_instr), .instruction_valid(w_valid),
        .fetch_pc(w_pc), .done(w_done)
    );

    function automatic logic [31:0] rd(input logic [31:0] a);
        return prog.exists(a) ? prog[a] : 32'h0;
    endfunction

    // Synchronous memories; garbage on non-request cycles must be ignored by the DUT.
    always @(posedge clk) imem_rdata <= imem_req ? rd(imem_addr) : 32'hDEAD_BEEF;
    always @(posedge clk) w_rdata    <= w_req ? {w_addr[31:2], 2'b11} : 32'h0;

    always @(negedge clk)
        if (rst_n && imem_req && imem_addr > max_addr) max_addr = imem_addr;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [31:0] pc, input logic [31:0] ins);
        exp_q.push_back('{pc: pc, ins: ins});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor: every accepted beat must match the head of the expected queue.
    always @(negedge clk) begin : mon
        beat_t e;
        if (rst_n && instruction_valid && !stall) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat: got pc=%h instr=%h, none expected", fetch_pc, instruction);
            end else begin
                e = exp_q.pop_front();
                if ({fetch_pc, instruction} !== {e.pc, e.ins}) begin
                    bad++;
                    $display("FAIL beat: got pc=%h instr=%h want pc=%h instr=%h",
                             fetch_pc, instruction, e.pc, e.ins);
                end
            end
        end
    end

    // Wrap-instance monitor: only the first beats after start are scripted.
    always @(negedge clk) begin : wmon
        beat_t e;
        if (w_rst_n && w_valid && w_q.size() != 0) begin
            e = w_q.pop_front();
            total++;
            if ({w_pc, w_instr} !== {e.pc, e.ins}) begin
                bad++;
                $display("FAIL wrap beat: got pc=%h instr=%h want pc=%h instr=%h",
                         w_pc, w_instr, e.pc, e.ins);
            end
        end
    end

    initial begin
        int n, k, reqs;
        logic [31:0] h_pc;
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        w_rst_n = 1'b0; w_start = 1'b0; w_stall = 1'b0; w_redir = 1'b0; w_redir_pc = '0;
        max_addr = '0;
        prog[32'h0] = 32'h00A0_0093;
        prog[32'h4] = 32'h00B0_0113;
        prog[32'h8] = 32'h0;

        // Reset values
        #12;
        check("rst imem_req", {31'b0, imem_req}, 32'h0);
        check("rst imem_addr", imem_addr, 32'h0);
        check("rst instruction", instruction, 32'h0);
        check("rst valid", {31'b0, instruction_valid}, 32'h0);
        check("rst fetch_pc", fetch_pc, 32'h0);
        check("rst done", {31'b0, done}, 32'h0);
        tick(); rst_n = 1'b1;
        tick(); tick();
        check("idle no req", {31'b0, imem_req}, 32'h0);

        // Basic program: two instructions then sentinel
        expect_beat(32'h0, 32'h00A0_0093);
        expect_beat(32'h4, 32'h00B0_0113);
        start = 1'b1;
        n = 0;
        while (!imem_req && n < 10) begin @(negedge clk); n++; end
        check("first req", {31'b0, imem_req}, 32'h1);
        check("first req addr", imem_addr, 32'h0);
        k = 0;
        while (!instruction_valid && k < 10) begin @(negedge clk); k++; end
        check("req->valid latency", k, 2);
        start = 1'b0;
        wait_done(30);
        check("halt done", {31'b0, done}, 32'h1);
        check("halt no req", {31'b0, imem_req}, 32'h0);
        check("max imem addr", max_addr, 32'h8);
        check("prog1 drained", exp_q.size(), 0);

        // Redirect out of HALT to 0x40, then stall for 5 cycles mid-stream
        for (int i = 0; i < 8; i++) begin
            prog[32'h40 + 4*i] = 32'h1300_0040 + 4*i;
            expect_beat(32'h40 + 4*i, 32'h1300_0040 + 4*i);
        end
        prog[32'h60] = 32'h0;
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        check("redir done falls", {31'b0, done}, 32'h0);
        check("redir req", {31'b0, imem_req}, 32'h1);
        check("redir addr", imem_addr, 32'h40);
        tick(); tick(); stall = 1'b1;
        @(negedge clk);
        h_pc = fetch_pc;
        check("stall head pc", h_pc, 32'h40);
        repeat (4) begin
            @(negedge clk);
            check("stall head held", fetch_pc, h_pc);
            check("stall valid held", {31'b0, instruction_valid}, 32'h1);
        end
        check("stall req off", {31'b0, imem_req}, 32'h0);
        tick(); stall = 1'b0;
        wait_done(40);
        check("stream done", {31'b0, done}, 32'h1);
        check("stream drained", exp_q.size(), 0);

        // Redirect to 0x103 while streaming with a read in flight
        for (int i = 0; i < 4; i++) prog[32'h80 + 4*i] = 32'h2200_0080 + 4*i;
        for (int i = 0; i < 3; i++) begin
            prog[32'h100 + 4*i] = 32'h3300_0100 + 4*i;
            expect_beat(32'h80 + 4*i, 32'h2200_0080 + 4*i);
        end
        for (int i = 0; i < 3; i++) expect_beat(32'h100 + 4*i, 32'h3300_0100 + 4*i);
        prog[32'h10C] = 32'h0;
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick(); redirect_valid = 1'b0;
        repeat (4) tick();
        check("pre-flush head", fetch_pc, 32'h88);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        check("flush valid low", {31'b0, instruction_valid}, 32'h0);
        check("flush addr", imem_addr, 32'h100);
        check("flush req", {31'b0, imem_req}, 32'h1);
        wait_done(40);
        check("flush done", {31'b0, done}, 32'h1);
        check("flush drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a stalled stream
        for (int i = 0; i < 4; i++) prog[32'h200 + 4*i] = 32'h4400_0200 + 4*i;
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h200; stall = 1'b1;
        tick(); redirect_valid = 1'b0;
        repeat (3) tick();
        check("pre-reset valid", {31'b0, instruction_valid}, 32'h1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async rst valid", {31'b0, instruction_valid}, 32'h0);
        check("async rst instr", instruction, 32'h0);
        check("async rst pc", fetch_pc, 32'h0);
        check("async rst addr", imem_addr, 32'h0);
        tick(); rst_n = 1'b1; stall = 1'b0;
        reqs = 0;
        repeat (6) begin @(negedge clk); if (imem_req) reqs++; end
        check("idle after reset", reqs, 0);
        expect_beat(32'h0, 32'h00A0_0093);
        expect_beat(32'h4, 32'h00B0_0113);
        tick(); start = 1'b1;
        wait_done(30);
        start = 1'b0;
        check("restart done", {31'b0, done}, 32'h1);
        check("restart drained", exp_q.size(), 0);

        // PC wrap from RESET_PC = 0xFFFFFFF8
        w_q.push_back('{pc: 32'hFFFF_FFF8, ins: 32'hFFFF_FFFB});
        w_q.push_back('{pc: 32'hFFFF_FFFC, ins: 32'hFFFF_FFFF});
        w_q.push_back('{pc: 32'h0000_0000, ins: 32'h0000_0003});
        tick(); w_rst_n = 1'b1;
        tick(); w_start = 1'b1;
        n = 0;
        while (w_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        check("wrap beats seen", w_q.size(), 0);
        w_rst_n = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
